// File: rtl/cpu_fetch_unit_pkg.sv
// Shared sizing helpers for the fetch front-end and its FIFOs.
package cpu_fetch_unit_pkg;

    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

    // One spare epoch bit beyond what the in-flight window needs.
    function automatic int epoch_bits(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

    function automatic int wrap_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Show-ahead synchronous FIFO with flush; head is valid whenever count != 0.
module cpu_fetch_fifo
    import cpu_fetch_unit_pkg::*;
#(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_bits(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= PW'(wrap_inc(int'(wr_ptr), DEPTH));
            if (do_pop)  rd_ptr <= PW'(wrap_inc(int'(rd_ptr), DEPTH));
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Q1 fetch front-end: credit-limited pipelined imem requests, epoch-tagged redirects,
// show-ahead prefetch buffer presenting {pc, pc_incr, insn} to Q2.
module cpu_fetch_unit
    import cpu_fetch_unit_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    input  logic            i_redirect_jal,
    input  logic [XLEN-1:0] i_redirect_jal_pc,
    input  logic            i_redirect_br,
    input  logic [XLEN-1:0] i_redirect_br_pc,
    output logic            o_insn_valid,
    input  logic            i_insn_ready,
    output logic [31:0]     o_insn,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_incr,
    output logic            o_misaligned
);
    localparam int EPOCH_W = epoch_bits(MAX_OUTSTANDING);
    localparam int FCW     = cnt_bits(FIFO_DEPTH);
    localparam int TCW     = cnt_bits(MAX_OUTSTANDING);
    localparam int SW      = cnt_bits(FIFO_DEPTH + MAX_OUTSTANDING);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_incr;
        logic [31:0]     insn;
    } fetch_entry_t;

    typedef struct packed {
        logic [EPOCH_W-1:0] epoch;
        logic [XLEN-1:0]    pc;
    } fetch_tag_t;

    logic [XLEN-1:0]    fetch_pc;
    logic [EPOCH_W-1:0] epoch;
    logic               running;
    logic               misaligned;
    logic [FCW-1:0]     fifo_count;
    logic [TCW-1:0]     outstanding;
    logic [SW-1:0]      credit_used;
    logic [XLEN-1:0]    target;
    logic               redirect;
    logic               accept;
    logic               rsp_ok;
    logic               push;
    logic               pop;
    logic               insn_valid;
    fetch_entry_t       entry_in;
    fetch_entry_t       head;
    fetch_tag_t         tag_in;
    fetch_tag_t         tag_head;

    assign redirect = i_redirect_br | i_redirect_jal;
    assign target   = i_redirect_br ? i_redirect_br_pc : i_redirect_jal_pc;

    // Every accepted request already owns a prefetch slot, so responses never need back-pressure.
    assign credit_used      = SW'(fifo_count) + SW'(outstanding);
    assign o_imem_req_valid = running && (outstanding < TCW'(MAX_OUTSTANDING))
                              && (credit_used < SW'(FIFO_DEPTH));
    assign o_imem_req_addr  = fetch_pc;
    assign accept           = o_imem_req_valid & i_imem_req_ready;

    assign rsp_ok     = i_imem_rsp_valid && (outstanding != '0);
    assign push       = rsp_ok && (tag_head.epoch == epoch) && !redirect;
    assign insn_valid = (fifo_count != '0);
    assign pop        = insn_valid & i_insn_ready;

    always_comb begin
        tag_in           = '0;
        tag_in.epoch     = epoch;
        tag_in.pc        = fetch_pc;
        entry_in         = '0;
        entry_in.pc      = tag_head.pc;
        entry_in.pc_incr = tag_head.pc + XLEN'(4);
        entry_in.insn    = i_imem_rsp_data;
    end

    assign o_insn_valid = insn_valid;
    assign o_insn       = insn_valid ? head.insn    : '0;
    assign o_pc         = insn_valid ? head.pc      : '0;
    assign o_pc_incr    = insn_valid ? head.pc_incr : '0;
    assign o_misaligned = misaligned;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc   <= RESET_PC;
            epoch      <= '0;
            running    <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            running    <= 1'b1;
            misaligned <= redirect && (target[1:0] != 2'b00);
            if (redirect) begin
                fetch_pc <= {target[XLEN-1:2], 2'b00};
                epoch    <= epoch + EPOCH_W'(1);
            end else if (accept) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    cpu_fetch_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_prefetch (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (entry_in),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // The tag queue occupancy is the in-flight request count; stale tags drain naturally.
    cpu_fetch_fifo #(.T(fetch_tag_t), .DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (1'b0),
        .push      (accept),
        .push_data (tag_in),
        .pop       (rsp_ok),
        .head      (tag_head),
        .count     (outstanding)
    );

    a_rsp_needs_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: in-order imem responder with random latency plus a PC-stream model.
module tb_cpu_fetch_unit;
    localparam int          XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUT    = 2;

    logic        clk;
    logic        i_rst_n;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect_jal;
    logic [31:0] i_redirect_jal_pc;
    logic        i_redirect_br;
    logic [31:0] i_redirect_br_pc;
    logic        o_insn_valid;
    logic        i_insn_ready;
    logic [31:0] o_insn;
    logic [31:0] o_pc;
    logic [31:0] o_pc_incr;
    logic        o_misaligned;

    cpu_fetch_unit #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (i_rst_n),
        .o_imem_req_valid  (o_imem_req_valid),
        .i_imem_req_ready  (i_imem_req_ready),
        .o_imem_req_addr   (o_imem_req_addr),
        .i_imem_rsp_valid  (i_imem_rsp_valid),
        .i_imem_rsp_data   (i_imem_rsp_data),
        .i_redirect_jal    (i_redirect_jal),
        .i_redirect_jal_pc (i_redirect_jal_pc),
        .i_redirect_br     (i_redirect_br),
        .i_redirect_br_pc  (i_redirect_br_pc),
        .o_insn_valid      (o_insn_valid),
        .i_insn_ready      (i_insn_ready),
        .o_insn            (o_insn),
        .o_pc              (o_pc),
        .o_pc_incr         (o_pc_incr),
        .o_misaligned      (o_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] acc_log[$];
    int          cyc = 0;
    int          rdy_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          bfm_accept;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Advance to the next falling edge and drive the imem side for the coming rising edge.
    task automatic tick();
        req_t r;
        @(negedge clk);
        cyc++;
        i_redirect_br  = 1'b0;
        i_redirect_jal = 1'b0;
        bfm_accept     = 1'b0;
        if (!i_rst_n) begin
            pend.delete();
            i_imem_rsp_valid = 1'b0;
            i_imem_req_ready = 1'b0;
            return;
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = $urandom;
        end
        i_imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
        if (o_imem_req_valid && i_imem_req_ready) begin
            r.addr = o_imem_req_addr;
            r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
            pend.push_back(r);
            acc_log.push_back(o_imem_req_addr);
            bfm_accept = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n          = 1'b0;
        i_insn_ready     = 1'b0;
        i_redirect_br    = 1'b0;
        i_redirect_jal   = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_req_ready = 1'b0;
        pend.delete();
        acc_log.delete();
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++; if (o_imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", o_imem_req_valid); end
        total++; if (o_imem_req_addr !== RESET_PC) begin bad++; $display("FAIL reset_req_addr: got %h want %h", o_imem_req_addr, RESET_PC); end
        total++; if (o_insn_valid !== 1'b0) begin bad++; $display("FAIL reset_insn_valid: got %b want 0", o_insn_valid); end
        total++; if (o_insn !== 32'h0) begin bad++; $display("FAIL reset_insn: got %h want 0", o_insn); end
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", o_pc); end
        total++; if (o_pc_incr !== 32'h0) begin bad++; $display("FAIL reset_pc_incr: got %h want 0", o_pc_incr); end
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned: got %b want 0", o_misaligned); end
        @(negedge clk);
        i_rst_n = 1'b1;
        total++; if (o_imem_req_valid !== 1'b0) begin bad++; $display("FAIL release_req_valid: got %b want 0", o_imem_req_valid); end
        tick();
        total++; if (o_imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", o_imem_req_valid); end
        total++; if (o_imem_req_addr !== RESET_PC) begin bad++; $display("FAIL first_req_addr: got %h want %h", o_imem_req_addr, RESET_PC); end
    endtask

    task automatic test_zero_wait();
        int n;
        logic [31:0] e;
        do_reset();
        rdy_pct = 100; lat_min = 0; lat_max = 0;
        i_insn_ready = 1'b1;
        tick();
        n = 0;
        while (!o_insn_valid && n < 20) begin
            tick();
            n++;
        end
        total++; if (n !== 2) begin bad++; $display("FAIL zw_startup: got %0d extra cycles want 2", n); end
        for (int k = 0; k < 8; k++) begin
            e = 32'(4 * k);
            total++; if (o_insn_valid !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d]: got %b want 1", k, o_insn_valid); end
            total++; if (o_pc !== e) begin bad++; $display("FAIL zw_pc[%0d]: got %h want %h", k, o_pc, e); end
            total++; if (o_pc_incr !== e + 32'd4) begin bad++; $display("FAIL zw_pc_incr[%0d]: got %h want %h", k, o_pc_incr, e + 32'd4); end
            total++; if (o_insn !== mem_word(e)) begin bad++; $display("FAIL zw_insn[%0d]: got %h want %h", k, o_insn, mem_word(e)); end
            tick();
        end
        for (int i = 0; i < acc_log.size(); i++) begin
            total++; if (acc_log[i] !== 32'(4 * i)) begin bad++; $display("FAIL zw_req_addr[%0d]: got %h want %h", i, acc_log[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        int got;
        logic [31:0] e;
        do_reset();
        rdy_pct = 100; lat_min = 0; lat_max = 0;
        i_insn_ready = 1'b0;
        repeat (12) tick();
        total++; if (acc_log.size() !== FIFO_DEPTH) begin bad++; $display("FAIL stall_req_count: got %0d want %0d", acc_log.size(), FIFO_DEPTH); end
        total++; if (o_imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", o_imem_req_valid); end
        total++; if (o_insn_valid !== 1'b1) begin bad++; $display("FAIL stall_head_valid: got %b want 1", o_insn_valid); end
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL stall_head_pc: got %h want 0", o_pc); end
        total++; if (o_insn !== mem_word(32'h0)) begin bad++; $display("FAIL stall_head_insn: got %h want %h", o_insn, mem_word(32'h0)); end
        i_insn_ready = 1'b1;
        got = 0;
        e   = 32'h0;
        for (int c = 0; c < 40 && got < 12; c++) begin
            if (o_insn_valid) begin
                total++; if (o_pc !== e) begin bad++; $display("FAIL drain_pc[%0d]: got %h want %h", got, o_pc, e); end
                total++; if (o_insn !== mem_word(e)) begin bad++; $display("FAIL drain_insn[%0d]: got %h want %h", got, o_insn, mem_word(e)); end
                e = e + 32'd4;
                got++;
            end
            tick();
        end
        total++; if (got !== 12) begin bad++; $display("FAIL drain_count: got %0d want 12", got); end
    endtask

    task automatic test_redirect();
        int n;
        bit found;
        do_reset();
        rdy_pct = 100; lat_min = 4; lat_max = 4;
        i_insn_ready = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            tick();
            n++;
            if (pend.size() == 2) begin
                if (pend[0].addr == 32'h8 && pend[1].addr == 32'hC) found = 1'b1;
            end
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL redir_setup: got found=%b want 1", found); end
        i_redirect_br    = 1'b1;
        i_redirect_br_pc = 32'h100;
        tick();
        total++; if (o_insn_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got valid=%b want 0", o_insn_valid); end
        total++; if (o_imem_req_addr !== 32'h100) begin bad++; $display("FAIL redir_req_addr: got %h want 100", o_imem_req_addr); end
        n = 0;
        while (!o_insn_valid && n < 40) begin
            tick();
            n++;
        end
        total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL redir_first_pc: got %h want 100", o_pc); end
        total++; if (o_insn !== mem_word(32'h100)) begin bad++; $display("FAIL redir_first_insn: got %h want %h", o_insn, mem_word(32'h100)); end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        rdy_pct = 100; lat_min = 0; lat_max = 0;
        i_insn_ready = 1'b1;
        repeat (5) tick();
        i_redirect_jal = 1'b1; i_redirect_jal_pc = 32'h40;
        i_redirect_br  = 1'b1; i_redirect_br_pc  = 32'h80;
        tick();
        total++; if (o_imem_req_addr !== 32'h80) begin bad++; $display("FAIL prio_req_addr: got %h want 80", o_imem_req_addr); end
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL prio_misaligned: got %b want 0", o_misaligned); end
        n = 0;
        while (!o_insn_valid && n < 20) begin tick(); n++; end
        total++; if (o_pc !== 32'h80) begin bad++; $display("FAIL prio_pc: got %h want 80", o_pc); end
        i_redirect_jal = 1'b1; i_redirect_jal_pc = 32'h102;
        tick();
        total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b want 1", o_misaligned); end
        total++; if (o_imem_req_addr !== 32'h100) begin bad++; $display("FAIL mis_req_addr: got %h want 100", o_imem_req_addr); end
        tick();
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL mis_pulse_end: got %b want 0", o_misaligned); end
        n = 0;
        while (!o_insn_valid && n < 20) begin tick(); n++; end
        total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL mis_pc: got %h want 100", o_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, exp_req, t;
        bit          exp_mis;
        int          consumed, last_redir, kind;
        do_reset();
        rdy_pct = 70; lat_min = 0; lat_max = 5;
        exp_pc = RESET_PC; exp_req = RESET_PC; exp_mis = 1'b0;
        consumed = 0; last_redir = -100;
        for (int c = 0; c < 2000; c++) begin
            tick();
            i_insn_ready = ($urandom_range(99) >= 30);
            total++; if (o_misaligned !== exp_mis) begin bad++; $display("FAIL rnd_misaligned@%0d: got %b want %b", c, o_misaligned, exp_mis); end
            if (o_imem_req_valid) begin
                total++; if (o_imem_req_addr !== exp_req) begin bad++; $display("FAIL rnd_req_addr@%0d: got %h want %h", c, o_imem_req_addr, exp_req); end
            end
            total++; if (pend.size() > MAX_OUT) begin bad++; $display("FAIL rnd_outstanding@%0d: got %0d want <=%0d", c, pend.size(), MAX_OUT); end
            if (o_insn_valid && i_insn_ready) begin
                total++; if (o_pc !== exp_pc) begin bad++; $display("FAIL rnd_pc@%0d: got %h want %h", c, o_pc, exp_pc); end
                total++; if (o_pc_incr !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_pc_incr@%0d: got %h want %h", c, o_pc_incr, exp_pc + 32'd4); end
                total++; if (o_insn !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_insn@%0d: got %h want %h", c, o_insn, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (c - last_redir >= 4 && $urandom_range(99) < 5) begin
                last_redir = c;
                kind = int'($urandom_range(2));
                i_redirect_jal_pc = ($urandom_range(1023) << 2) | (($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0);
                i_redirect_br_pc  = ($urandom_range(1023) << 2) | (($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0);
                i_redirect_jal    = (kind != 1);
                i_redirect_br     = (kind != 0);
                t       = i_redirect_br ? i_redirect_br_pc : i_redirect_jal_pc;
                exp_mis = ((t % 4) != 0);
                exp_pc  = t - (t % 4);
                exp_req = t - (t % 4);
            end else begin
                exp_mis = 1'b0;
                if (bfm_accept) exp_req = exp_req + 32'd4;
            end
        end
        total++; if (consumed <= 200) begin bad++; $display("FAIL rnd_progress: got %0d consumed want >200", consumed); end
    endtask

    task automatic test_reset_midburst();
        int n;
        do_reset();
        rdy_pct = 100; lat_min = 3; lat_max = 3;
        i_insn_ready = 1'b1;
        n = 0;
        while (pend.size() != 2 && n < 30) begin tick(); n++; end
        total++; if (pend.size() !== 2) begin bad++; $display("FAIL mid_setup: got %0d in flight want 2", pend.size()); end
        i_rst_n = 1'b0;
        i_imem_rsp_valid = 1'b0;
        pend.delete();
        #1;
        total++; if (o_imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_req_valid: got %b want 0", o_imem_req_valid); end
        total++; if (o_imem_req_addr !== RESET_PC) begin bad++; $display("FAIL mid_req_addr: got %h want %h", o_imem_req_addr, RESET_PC); end
        total++; if (o_insn_valid !== 1'b0) begin bad++; $display("FAIL mid_insn_valid: got %b want 0", o_insn_valid); end
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL mid_pc: got %h want 0", o_pc); end
        total++; if (o_insn !== 32'h0) begin bad++; $display("FAIL mid_insn: got %h want 0", o_insn); end
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        acc_log.delete();
        n = 0;
        while (acc_log.size() == 0 && n < 10) begin tick(); n++; end
        if (acc_log.size() == 0) begin
            total++; bad++; $display("FAIL mid_restart: got no request want one");
        end else begin
            total++; if (acc_log[0] !== RESET_PC) begin bad++; $display("FAIL mid_first_addr: got %h want %h", acc_log[0], RESET_PC); end
        end
        n = 0;
        while (!o_insn_valid && n < 20) begin tick(); n++; end
        total++; if (o_pc !== RESET_PC) begin bad++; $display("FAIL mid_first_pc: got %h want %h", o_pc, RESET_PC); end
    endtask

    initial begin
        i_rst_n           = 1'b0;
        i_imem_req_ready  = 1'b0;
        i_imem_rsp_valid  = 1'b0;
        i_imem_rsp_data   = 32'h0;
        i_redirect_jal    = 1'b0;
        i_redirect_jal_pc = 32'h0;
        i_redirect_br     = 1'b0;
        i_redirect_br_pc  = 32'h0;
        i_insn_ready      = 1'b0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect();
        test_priority();
        test_random();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
